mux_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the n-way select tree (Mux). It shares one data_width path among 2^switch_bits requesters.
- Drives the mux select and the one-hot grants, and captures the mux output into a single output register with a valid/ready handshake.
- Sits between requesting units and the downstream consumer of the shared bus.

---
 rtl/mux_arbiter.sv | 142 ++++++++++++++
 tb/tb_mux_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// mux_arbiter
//   Round-robin arbiter and sequencer for an N-way select tree (N = 2**switch_bits).
//   One requester at a time is granted. The arbiter drives the mux select and a
//   one-hot grant. It captures the mux output into one output register with a
//   valid/ready handshake. A grant lasts until the requester flags its last beat,
//   until max_burst beats have been taken, or until it drops its request.
//
// Parameters
//   switch_bits : select width, must be >= 1
//   data_width  : width of mux_IN / data_OUT
//   max_burst   : beats per grant before forced rotation, 1..255
//
// Ports
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset, released synchronously by the system
//   req_IN    : per-requester request, held while the requester has beats
//   last_IN   : per-requester last-beat flag, only the granted bit is looked at
//   mux_IN    : output of the mux tree, whose select is sel_OUT
//   ready_IN  : downstream takes data_OUT this cycle
//   sel_OUT   : registered mux select
//   gnt_OUT   : registered one-hot grant, or all zero
//   data_OUT  : captured beat
//   valid_OUT : data_OUT holds a beat that has not been consumed yet
module mux_arbiter #(
  parameter int switch_bits = 2,
  parameter int data_width  = 8,
  parameter int max_burst   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [(1<<switch_bits)-1:0]   req_IN,
  input  logic [(1<<switch_bits)-1:0]   last_IN,
  input  logic [data_width-1:0]         mux_IN,
  input  logic                          ready_IN,
  output logic [switch_bits-1:0]        sel_OUT,
  output logic [(1<<switch_bits)-1:0]   gnt_OUT,
  output logic [data_width-1:0]         data_OUT,
  output logic                          valid_OUT
);

  localparam int N = 1 << switch_bits;
  localparam logic [7:0] MAX_BURST_C = 8'(max_burst);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state;
  logic [switch_bits-1:0] last_grant;
  logic [7:0]             beat_cnt;

  logic                   req_sel;
  logic                   last_sel;
  logic                   accept;
  logic                   burst_done;
  logic [switch_bits-1:0] winner;

  // Round-robin pick. The scan starts one past the previous winner. The index
  // wraps naturally because it is switch_bits wide and N is a power of two.
  // The previous winner is looked at last, so it has the lowest priority.
  function automatic logic [switch_bits-1:0] rr_pick(
    input logic [N-1:0]           req,
    input logic [switch_bits-1:0] prev
  );
    logic [switch_bits-1:0] idx;
    logic                   found;
    rr_pick = prev;
    found   = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = prev + switch_bits'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [N-1:0] onehot(input logic [switch_bits-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  always_comb begin
    req_sel    = req_IN[sel_OUT];
    last_sel   = last_IN[sel_OUT];
    // A beat moves when the granted requester still requests and the output
    // register is free, or is being drained in the same cycle.
    accept     = (state == BUSY) && req_sel && (!valid_OUT || ready_IN);
    burst_done = (beat_cnt + 8'd1) == MAX_BURST_C;
    winner     = rr_pick(req_IN, last_grant);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= switch_bits'(N - 1);
      beat_cnt   <= 8'd0;
      sel_OUT    <= '0;
      gnt_OUT    <= '0;
      data_OUT   <= '0;
      valid_OUT  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Nothing is accepted while idle, so a pending beat only drains.
          if (valid_OUT && ready_IN) valid_OUT <= 1'b0;
          if (|req_IN) begin
            sel_OUT  <= winner;
            gnt_OUT  <= onehot(winner);
            beat_cnt <= 8'd0;
            state    <= BUSY;
          end else begin
            gnt_OUT  <= '0;
          end
        end

        BUSY: begin
          if (accept) begin
            data_OUT  <= mux_IN;
            valid_OUT <= 1'b1;
            beat_cnt  <= beat_cnt + 8'd1;
            if (last_sel || burst_done) begin
              state      <= IDLE;
              gnt_OUT    <= '0;
              last_grant <= sel_OUT;
            end
          end else begin
            if (valid_OUT && ready_IN) valid_OUT <= 1'b0;
            // Abandon: the granted requester dropped its request. Rotation
            // still moves past it so it does not win again straight away.
            if (!req_sel) begin
              state      <= IDLE;
              gnt_OUT    <= '0;
              last_grant <= sel_OUT;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb_mux_arbiter
//   Drives two arbiters (max_burst 4 and max_burst 1) from the same requesters.
//   Each arbiter's outputs are compared on every cycle against a behavioural
//   model. Directed scenarios add fixed expectations at the key points.
module tb_mux_arbiter;

  localparam int SB = 2;
  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  last;
  logic          ready;
  logic [DW-1:0] src [N];

  logic [SB-1:0] sel_a, sel_b;
  logic [N-1:0]  gnt_a, gnt_b;
  logic [DW-1:0] data_a, data_b;
  logic          valid_a, valid_b;
  logic [DW-1:0] mux_a, mux_b;

  // Each arbiter has its own mux tree selecting among the shared sources.
  assign mux_a = src[sel_a];
  assign mux_b = src[sel_b];

  always #5 clk = ~clk;

  mux_arbiter #(.switch_bits(SB), .data_width(DW), .max_burst(4)) dut_a (
    .clk(clk), .rst(rst), .req_IN(req), .last_IN(last), .mux_IN(mux_a),
    .ready_IN(ready), .sel_OUT(sel_a), .gnt_OUT(gnt_a), .data_OUT(data_a),
    .valid_OUT(valid_a)
  );

  mux_arbiter #(.switch_bits(SB), .data_width(DW), .max_burst(1)) dut_b (
    .clk(clk), .rst(rst), .req_IN(req), .last_IN(last), .mux_IN(mux_b),
    .ready_IN(ready), .sel_OUT(sel_b), .gnt_OUT(gnt_b), .data_OUT(data_b),
    .valid_OUT(valid_b)
  );

  int checks = 0;
  int errors = 0;

  // Model state, index 0 for dut_a and index 1 for dut_b.
  int mb      [2] = '{4, 1};
  int m_busy  [2];
  int m_sel   [2];
  int m_gnt   [2];
  int m_data  [2];
  int m_valid [2];
  int m_cnt   [2];
  int m_lg    [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_sel[k] = 0; m_gnt[k] = 0; m_data[k] = 0;
      m_valid[k] = 0; m_cnt[k] = 0; m_lg[k] = N - 1;
    end
  endtask

  task automatic end_grant(input int k);
    m_busy[k] = 0;
    m_gnt[k]  = 0;
    m_lg[k]   = m_sel[k];
  endtask

  // One rising edge, applied with the inputs present at that edge.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int s;
      int win;
      bit acc;
      s   = m_sel[k];
      acc = (m_busy[k] != 0) && req[s] && (m_valid[k] == 0 || ready);
      if (m_busy[k] == 0) begin
        if (m_valid[k] != 0 && ready) m_valid[k] = 0;
        if (req != 0) begin
          win = -1;
          for (int i = 1; i <= N; i++) begin
            int c;
            c = (m_lg[k] + i) % N;
            if (win < 0 && req[c]) win = c;
          end
          m_sel[k] = win; m_gnt[k] = 1 << win; m_cnt[k] = 0; m_busy[k] = 1;
        end else begin
          m_gnt[k] = 0;
        end
      end else if (acc) begin
        m_data[k]  = src[s];
        m_valid[k] = 1;
        m_cnt[k]   = m_cnt[k] + 1;
        if (last[s] || m_cnt[k] == mb[k]) end_grant(k);
      end else begin
        if (m_valid[k] != 0 && ready) m_valid[k] = 0;
        if (!req[s]) end_grant(k);
      end
    end
  endtask

  task automatic check_all();
    chk("a_sel",   32'(sel_a),   32'(m_sel[0]));
    chk("a_gnt",   32'(gnt_a),   32'(m_gnt[0]));
    chk("a_data",  32'(data_a),  32'(m_data[0]));
    chk("a_valid", 32'(valid_a), 32'(m_valid[0]));
    chk("b_sel",   32'(sel_b),   32'(m_sel[1]));
    chk("b_gnt",   32'(gnt_b),   32'(m_gnt[1]));
    chk("b_data",  32'(data_b),  32'(m_data[1]));
    chk("b_valid", 32'(valid_b), 32'(m_valid[1]));
  endtask

  task automatic new_src();
    for (int i = 0; i < N; i++) src[i] = DW'($urandom);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_reset();
    else model_edge();
    #1;
    check_all();
    new_src();
  endtask

  // Reset asserted between clock edges. The outputs must already be zero
  // before the next edge arrives.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async_sel_a",   32'(sel_a),   32'd0);
    chk("rst_async_gnt_a",   32'(gnt_a),   32'd0);
    chk("rst_async_data_a",  32'(data_a),  32'd0);
    chk("rst_async_valid_a", 32'(valid_a), 32'd0);
    chk("rst_async_gnt_b",   32'(gnt_b),   32'd0);
    chk("rst_async_valid_b", 32'(valid_b), 32'd0);
    model_reset();
    req = '0; last = '0; ready = 1'b1;
    step();
    step();
    rst = 1'b1;
  endtask

  logic [3:0]    pat_a [11];
  logic [3:0]    pat_b [11];
  logic [3:0]    pat_r [9];
  logic [DW-1:0] exp_d;

  initial begin
    rst = 1'b0; req = '0; last = '0; ready = 1'b1;
    new_src();
    model_reset();
    step();
    step();
    rst = 1'b1;

    // Two requesters, long bursts versus single-beat bursts.
    pat_a = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h1};
    pat_b = '{4'h1, 4'h0, 4'h4, 4'h0, 4'h1, 4'h0, 4'h4, 4'h0, 4'h1, 4'h0, 4'h4};
    do_reset();
    req = 4'b0101; last = '0; ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step();
      chk("t1_gnt_a", 32'(gnt_a), 32'(pat_a[i]));
      chk("t1_gnt_b", 32'(gnt_b), 32'(pat_b[i]));
    end

    // Requester 2 ends its burst with last on beat 2.
    do_reset();
    req = 4'b0100;
    step();
    chk("t2_gnt_arb", 32'(gnt_a), 32'h4);
    step();
    chk("t2_gnt_beat1", 32'(gnt_a), 32'h4);
    last = 4'b0100;
    step();
    chk("t2_gnt_end", 32'(gnt_a), 32'h0);
    chk("t2_valid", 32'(valid_a), 32'h1);
    last = '0;
    step();
    chk("t2_regrant", 32'(gnt_a), 32'h4);

    // Backpressure after beat 1 of requester 1.
    do_reset();
    req = 4'b0010;
    step();
    exp_d = src[1];
    step();
    chk("t3_beat1", 32'(data_a), 32'(exp_d));
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_hold_data",  32'(data_a),  32'(exp_d));
      chk("t3_hold_valid", 32'(valid_a), 32'h1);
      chk("t3_hold_gnt",   32'(gnt_a),   32'h2);
    end
    ready = 1'b1;
    exp_d = src[1];
    step();
    chk("t3_beat2", 32'(data_a), 32'(exp_d));
    step();
    step();
    chk("t3_burst_end", 32'(gnt_a), 32'h0);

    // Requester 3 abandons after one beat, then requester 0 wins.
    do_reset();
    req = 4'b1000;
    step();
    chk("t4_gnt3", 32'(gnt_a), 32'h8);
    step();
    req = 4'b0000;
    step();
    chk("t4_abandon", 32'(gnt_a), 32'h0);
    req = 4'b1001;
    step();
    chk("t4_next", 32'(gnt_a), 32'h1);

    // Reset in the middle of a burst, with a beat pending.
    do_reset();
    req = 4'b1111;
    step();
    step();
    chk("t5_pending", 32'(valid_a), 32'h1);
    do_reset();
    req = 4'b0110;
    step();
    chk("t5_first", 32'(gnt_a), 32'h2);

    // Single-beat bursts rotate through all requesters.
    pat_r = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      step();
      chk("t6_rot_b", 32'(gnt_b), 32'(pat_r[i]));
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      last  = 4'($urandom & $urandom);
      ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
